pov_led_shift_driver: RTL and testbench
=======================================

# pov_led_shift_driver

Output stage of the POV LED path. It sits directly downstream of `top_leds`, takes each 16-bit column word that block produces on `ledsOut`, and shifts it MSB-first into external daisy-chained serial-in/parallel-out LED driver registers (74HC595-class). After each frame it pulses a storage latch. A one-deep pending buffer absorbs a column update that arrives mid-frame.

## Interface
- `WIDTH`, 16: bits per frame; equals the `ledsOut` width.
- `CLK_DIV`, 2: `clk` cycles per `sclk` half-period; legal values are ≥1.
- `LATCH_CYCLES`, 2: `clk` cycles that `latch` is held high; legal values are ≥1.

Ports (name, direction, width, meaning):
- `clk`, in, 1: system clock; the block has one clock.
- `rst`, in, 1: synchronous, active-high reset.
- `leds_in`, in, WIDTH: column word; connects to `top_leds.ledsOut`.
- `load`, in, 1: single-cycle strobe meaning "`leds_in` is a new word".
- `sdo`, out, 1: serial data to the first driver register.
- `sclk`, out, 1: shift clock; drivers sample `sdo` on its rising edge.
- `latch`, out, 1: storage-register clock pulse.
- `busy`, out, 1: high while a frame is shifting or latching.
- `overrun`, out, 1: single-cycle pulse when a buffered word is overwritten before it is sent.

## Operation
- **Reset:** `sdo`, `sclk`, `latch`, `busy` and `overrun` are all 0, the pending buffer is empty, and the FSM is in IDLE. A reset mid-frame aborts the frame immediately and no latch pulse is issued.
- **FSM states:** IDLE → SHIFT → LATCH → IDLE, or LATCH → SHIFT when a word is pending.
- **IDLE:** when `load`=1, capture `leds_in` into the shift register and go to SHIFT.
- **SHIFT:**
  - Each bit takes 2·CLK_DIV cycles: `sclk` is low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - `sdo` changes only on the first cycle of a low phase. Bit order is WIDTH-1 down to 0.
  - After the high phase of bit 0, `sclk` returns low and the FSM moves to LATCH.
- **LATCH:** `latch` is high for LATCH_CYCLES cycles while `sclk` stays low.
  - On exit, if the pending buffer is valid, load that word into the shift register, clear the buffer and go to SHIFT.
  - Otherwise go to IDLE.
- **`load` while `busy`=1:**
  - The word goes into the pending buffer.
  - If the buffer already holds a word, the new word overwrites it and `overrun` pulses high on the next cycle.
- **`load` on the final LATCH cycle:** the word is treated as pending and is sent as the next frame.
- **Data outside SHIFT:** `sdo` holds the last bit shifted (bit 0). It returns to 0 only on reset.
- **Counter widths:** the bit counter uses $clog2(WIDTH) bits; the divider counter uses $clog2(CLK_DIV) bits with a minimum of 1. All counters wrap only at the terminal values defined above.

## Timing
- Let `load` be sampled high in IDLE at cycle t.
- `busy`=1 from cycle t+1. The first `sdo` bit (WIDTH-1) is valid at t+1 with `sclk`=0.
- SHIFT occupies cycles t+1 through t+2·WIDTH·CLK_DIV. With default parameters that is cycles t+1 to t+64.
- The first `sclk` rising edge occurs at t+1+CLK_DIV, which is t+3 with defaults.
- `latch`=1 for cycles t+2·WIDTH·CLK_DIV+1 through t+2·WIDTH·CLK_DIV+LATCH_CYCLES. With defaults that is t+65 and t+66.
- With no word pending, `busy`=0 from t+2·WIDTH·CLK_DIV+LATCH_CYCLES+1, which is t+67 with defaults.
- With a word pending, SHIFT restarts at t+67 and `busy` stays high continuously.
- `load` has no ready/acknowledge signal; the pending buffer plus `overrun` is the flow-control contract.

## Structure
- Package `pov_pkg`:
  - `LED_WIDTH`=16, shared with `top_leds`.
  - The FSM state enum `{IDLE, SHIFT, LATCH}`.
- Sub-module `pov_sclk_gen`: a divide-by-CLK_DIV clock-enable generator.
  - It produces single-cycle `fall_en` and `rise_en` strobes.
  - It is held cleared while the FSM is outside SHIFT.
  - The FSM uses these strobes. No derived clocks are used: `sclk` is a registered output.

## Test plan
- **Reset values:** hold `rst` high for 3 cycles → all outputs 0. Pulse `load` with `leds_in`=16'hFFFF in the same cycle as `rst` → no frame starts.
- **Single frame:** `leds_in`=16'hA5C3 with a `load` pulse at t → `sdo` sampled on the 16 `sclk` rising edges reads 1010_0101_1100_0011. `latch` is high at t+65 and t+66, and `busy` falls at t+67.
- **Back-to-back:** load 16'h0001, then load 16'h8000 at t+10 → frame 2 starts at t+67 without `busy` dropping. The first bit of frame 2 is 1 and `overrun` stays 0.
- **Overrun:** during a frame, load 16'h1111 at t+5 and then 16'h2222 at t+6 → `overrun` pulses at t+7 and the next frame shifts 16'h2222.
- **Reset mid-frame:** assert `rst` at t+30 → outputs are 0 at t+31, `latch` never pulses, and the pending word is dropped.
- **Parameter sweep:** CLK_DIV=1 and LATCH_CYCLES=1 → frame length is 33 cycles with `busy` low at t+34. A scoreboard checks shifted data against `leds_in` across 100 random words.

Source files
------------

// File: rtl/pov_pkg.sv
// Shared definitions for the POV LED output path: column width and the
// serial driver's frame state machine encoding.
package pov_pkg;

    localparam int LED_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        LATCH
    } state_t;

endpackage

// File: rtl/pov_sclk_gen.sv
// Divide-by-CLK_DIV clock-enable generator: emits single-cycle strobes at the
// end of each sclk low phase (rise_en) and high phase (fall_en).
module pov_sclk_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic rise_en,
    output logic fall_en
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;
    logic          phase;
    logic          wrap;

    assign wrap    = en && (cnt == LAST);
    assign rise_en = wrap && !phase;
    assign fall_en = wrap && phase;

    // Held cleared whenever disabled so every frame starts at the top of a low phase.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (cnt == LAST) begin
            cnt   <= '0;
            phase <= ~phase;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pov_led_shift_driver.sv
// Shifts each column word MSB-first into daisy-chained 595-class registers,
// pulses the storage latch per frame and buffers one word arriving mid-frame.
module pov_led_shift_driver
    import pov_pkg::*;
#(
    parameter int WIDTH        = LED_WIDTH,
    parameter int CLK_DIV      = 2,
    parameter int LATCH_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] leds_in,
    input  logic             load,
    output logic             sdo,
    output logic             sclk,
    output logic             latch,
    output logic             busy,
    output logic             overrun
);

    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int LW = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [LW-1:0] LAT_LAST = LW'(LATCH_CYCLES - 1);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] shreg;
    logic [BW-1:0]    bit_cnt;
    logic [LW-1:0]    lat_cnt;
    logic             pend_valid;
    logic [WIDTH-1:0] pend_word;
    logic             rise_en;
    logic             fall_en;
    logic             lat_last;
    logic             latch_exit;
    logic             frame_start;
    logic [WIDTH-1:0] frame_word;

    assign busy  = (state != IDLE);
    assign latch = (state == LATCH);

    pov_sclk_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_sclk_gen (
        .clk    (clk),
        .rst    (rst),
        .en     (state == SHIFT),
        .rise_en(rise_en),
        .fall_en(fall_en)
    );

    // A load on the final latch cycle counts as pending, so it wins over the buffer.
    always_comb begin
        state_next  = state;
        lat_last    = (lat_cnt == LAT_LAST);
        latch_exit  = (state == LATCH) && lat_last;
        frame_start = 1'b0;
        frame_word  = leds_in;
        case (state)
            IDLE: begin
                if (load) begin
                    state_next  = SHIFT;
                    frame_start = 1'b1;
                end
            end
            SHIFT: begin
                if (fall_en && (bit_cnt == '0)) state_next = LATCH;
            end
            LATCH: begin
                if (lat_last) begin
                    if (load || pend_valid) begin
                        state_next  = SHIFT;
                        frame_start = 1'b1;
                        frame_word  = load ? leds_in : pend_word;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            shreg      <= '0;
            bit_cnt    <= '0;
            lat_cnt    <= '0;
            pend_valid <= 1'b0;
            pend_word  <= '0;
            sdo        <= 1'b0;
            sclk       <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state   <= state_next;
            overrun <= load && busy && pend_valid;

            if (frame_start) begin
                sdo     <= frame_word[WIDTH-1];
                shreg   <= {frame_word[WIDTH-2:0], 1'b0};
                bit_cnt <= BIT_LAST;
            end else if ((state == SHIFT) && fall_en && (bit_cnt != '0)) begin
                sdo     <= shreg[WIDTH-1];
                shreg   <= {shreg[WIDTH-2:0], 1'b0};
                bit_cnt <= bit_cnt - 1'b1;
            end

            if ((state == SHIFT) && rise_en) begin
                sclk <= 1'b1;
            end else if (fall_en) begin
                sclk <= 1'b0;
            end

            lat_cnt <= ((state == LATCH) && !lat_last) ? lat_cnt + 1'b1 : '0;

            if (latch_exit) begin
                pend_valid <= 1'b0;
            end else if (load && busy) begin
                pend_valid <= 1'b1;
                pend_word  <= leds_in;
            end
        end
    end

endmodule

// File: tb/tb_pov_led_shift_driver.sv
// Directed bench for pov_led_shift_driver: default instance plus a
// CLK_DIV=1 / LATCH_CYCLES=1 instance checked with a random-word scoreboard.
module tb_pov_led_shift_driver;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_a = 1'b0;
    logic [15:0] leds_a = '0;
    logic        sdo_a, sclk_a, latch_a, busy_a, overrun_a;
    logic        load_b = 1'b0;
    logic [15:0] leds_b = '0;
    logic        sdo_b, sclk_b, latch_b, busy_b, overrun_b;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic        rst;
        logic        load;
        logic [15:0] leds;
        logic [4:0]  exp;
    } vec_t;

    vec_t        vecs[13];
    logic [15:0] scoreboard[$];

    always #5 clk = ~clk;

    pov_led_shift_driver dut_a (
        .clk    (clk),
        .rst    (rst),
        .leds_in(leds_a),
        .load   (load_a),
        .sdo    (sdo_a),
        .sclk   (sclk_a),
        .latch  (latch_a),
        .busy   (busy_a),
        .overrun(overrun_a)
    );

    pov_led_shift_driver #(
        .WIDTH       (16),
        .CLK_DIV     (1),
        .LATCH_CYCLES(1)
    ) dut_b (
        .clk    (clk),
        .rst    (rst),
        .leds_in(leds_b),
        .load   (load_b),
        .sdo    (sdo_b),
        .sclk   (sclk_b),
        .latch  (latch_b),
        .busy   (busy_b),
        .overrun(overrun_b)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input vec_t v);
        rst    = v.rst;
        load_a = v.load;
        leds_a = v.leds;
        step();
    endtask

    task automatic start_frame_a(input logic [15:0] word);
        load_a = 1'b1;
        leds_a = word;
        step();
        load_a = 1'b0;
    endtask

    // Entered while observing cycle t+rel_start; returns while observing t+67.
    task automatic watch_frame_a(input logic [15:0] exp_word, input int rel_start,
                                 input logic [15:0] init_bits, input int init_n,
                                 input int ld_rel1, input logic [15:0] ld_w1,
                                 input int ld_rel2, input logic [15:0] ld_w2,
                                 input int ov_rel, input bit pending_next, input string name);
        logic [15:0] got;
        int          n;
        logic        prev;
        logic [2:0]  exp_ctl;
        got  = init_bits;
        n    = init_n;
        prev = sclk_a;
        for (int rel = rel_start; rel <= 67; rel++) begin
            if (sclk_a === 1'b1 && prev === 1'b0) begin
                got = {got[14:0], sdo_a};
                n++;
            end
            prev       = sclk_a;
            exp_ctl[2] = (rel == 65) || (rel == 66);
            exp_ctl[1] = (rel <= 66) ? 1'b1 : pending_next;
            exp_ctl[0] = (rel == ov_rel);
            check_output($sformatf("%s latch/busy/overrun @t+%0d", name, rel),
                         {29'd0, latch_a, busy_a, overrun_a}, {29'd0, exp_ctl});
            if (rel == 67) break;
            load_a = (rel == ld_rel1) || (rel == ld_rel2);
            leds_a = (rel == ld_rel2) ? ld_w2 : ld_w1;
            step();
        end
        load_a = 1'b0;
        check_output($sformatf("%s bit count", name), n, 16);
        check_output($sformatf("%s shifted word", name), {16'd0, got}, {16'd0, exp_word});
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // {rst, load, leds_in} -> expected {sdo, sclk, latch, busy, overrun} next cycle
        vecs[0]  = '{1'b1, 1'b0, 16'h0000, 5'b00000};
        vecs[1]  = '{1'b1, 1'b0, 16'h0000, 5'b00000};
        vecs[2]  = '{1'b1, 1'b1, 16'hFFFF, 5'b00000};
        vecs[3]  = '{1'b0, 1'b0, 16'hFFFF, 5'b00000};
        vecs[4]  = '{1'b0, 1'b1, 16'hA5C3, 5'b10010};
        vecs[5]  = '{1'b0, 1'b0, 16'h0000, 5'b10010};
        vecs[6]  = '{1'b0, 1'b0, 16'h0000, 5'b11010};
        vecs[7]  = '{1'b0, 1'b0, 16'h0000, 5'b11010};
        vecs[8]  = '{1'b0, 1'b0, 16'h0000, 5'b00010};
        vecs[9]  = '{1'b0, 1'b0, 16'h0000, 5'b00010};
        vecs[10] = '{1'b0, 1'b0, 16'h0000, 5'b01010};
        vecs[11] = '{1'b0, 1'b0, 16'h0000, 5'b01010};
        vecs[12] = '{1'b0, 1'b0, 16'h0000, 5'b10010};

        step();
        for (int i = 0; i < 13; i++) begin
            apply_stimulus(vecs[i]);
            check_output($sformatf("vector %0d outputs", i),
                         {27'd0, sdo_a, sclk_a, latch_a, busy_a, overrun_a}, {27'd0, vecs[i].exp});
        end
        load_a = 1'b0;

        // Vectors 4..12 covered t+1..t+9 of the A5C3 frame (bits 15,14 already out).
        watch_frame_a(16'hA5C3, 9, 16'h0002, 2, -1, 16'h0, -1, 16'h0, -1, 1'b0, "single");

        start_frame_a(16'h0001);
        watch_frame_a(16'h0001, 1, 16'h0, 0, 10, 16'h8000, -1, 16'h0, -1, 1'b1, "b2b frame1");
        check_output("b2b frame2 first bit", {31'd0, sdo_a}, 32'd1);
        watch_frame_a(16'h8000, 1, 16'h0, 0, -1, 16'h0, -1, 16'h0, -1, 1'b0, "b2b frame2");

        start_frame_a(16'h0F0F);
        watch_frame_a(16'h0F0F, 1, 16'h0, 0, 5, 16'h1111, 6, 16'h2222, 7, 1'b1, "overrun frame1");
        watch_frame_a(16'h2222, 1, 16'h0, 0, -1, 16'h0, -1, 16'h0, -1, 1'b0, "overrun frame2");

        begin
            logic activity;
            start_frame_a(16'hFFFF);
            for (int rel = 1; rel < 30; rel++) begin
                load_a = (rel == 10);
                leds_a = 16'h1234;
                step();
            end
            load_a = 1'b0;
            rst = 1'b1;
            step();
            rst = 1'b0;
            check_output("mid-frame reset outputs", {27'd0, sdo_a, sclk_a, latch_a, busy_a, overrun_a}, 32'd0);
            activity = 1'b0;
            for (int k = 0; k < 80; k++) begin
                step();
                if (latch_a !== 1'b0 || busy_a !== 1'b0 || sclk_a !== 1'b0) activity = 1'b1;
            end
            check_output("post-reset no latch/busy", {31'd0, activity}, 32'd0);
        end

        for (int w = 0; w < 100; w++) begin
            logic [15:0] word;
            logic [15:0] got;
            logic [15:0] exp_word;
            logic        prev;
            int          rel;
            int          low_rel;
            int          lat_n;
            int          lat_at;
            word = 16'($urandom);
            scoreboard.push_back(word);
            load_b = 1'b1;
            leds_b = word;
            step();
            load_b  = 1'b0;
            leds_b  = 16'($urandom);
            got     = '0;
            prev    = sclk_b;
            rel     = 1;
            low_rel = -1;
            lat_n   = 0;
            lat_at  = -1;
            while (rel <= 60) begin
                if (sclk_b === 1'b1 && prev === 1'b0) got = {got[14:0], sdo_b};
                prev = sclk_b;
                if (latch_b === 1'b1) begin
                    lat_n++;
                    lat_at = rel;
                end
                if (busy_b === 1'b0) begin
                    low_rel = rel;
                    break;
                end
                step();
                rel++;
            end
            exp_word = scoreboard.pop_front();
            check_output($sformatf("sweep word %0d data", w), {16'd0, got}, {16'd0, exp_word});
            check_output($sformatf("sweep word %0d busy-low cycle", w), low_rel, 34);
            check_output($sformatf("sweep word %0d latch count/cycle", w), (lat_n << 8) | lat_at, (1 << 8) | 33);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
